fetch_ctrl: RTL and testbench

Program-counter sequencer for the 9-bit RISC core. It owns the PC that addresses the combinational instruction ROM (`imem`) and runs a start/run/halt state machine. It applies stalls and taken branches from the execute stage, and detects the halt encoding. It also keeps cycle and retired-instruction counters for testbench scoring.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 74 +++++++
 tb/tb_fetch_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the 9-bit core front end
package cpu_pkg;

   localparam int PC_W   = 8;
   localparam int INST_W = 9;

   // Also the imem default, so running off the end of a program stops the core.
   localparam logic [INST_W-1:0] HALT_INST = 9'h1FF;

   typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus: imem/execute inputs, PC and status outputs
interface fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   import cpu_pkg::*;

   logic              start;
   logic [INST_W-1:0] inst;
   logic              stall;
   logic              branch_taken;
   logic [PC_W-1:0]   branch_target;
   logic [PC_W-1:0]   pc;
   logic              inst_valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  inst_count;

   modport master (
      output start, inst, stall, branch_taken, branch_target,
      input  pc, inst_valid, busy, done, cycle_count, inst_count
   );

   modport slave (
      input  start, inst, stall, branch_taken, branch_target,
      output pc, inst_valid, busy, done, cycle_count, inst_count
   );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         count_q <= '0;
      end else if (en_i && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencer with IDLE/RUN/HALT control and performance counters
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   fetch_ctrl_if.slave bus
);

   fetch_state_t    state_q;
   logic [PC_W-1:0] pc_q;
   logic            is_halt;
   logic            issue;
   logic            cnt_clr;

   assign is_halt = (bus.inst == HALT_INST);
   assign issue   = (state_q == RUN) && !bus.stall && !is_halt;

   // Counters restart whenever a run is launched; in IDLE they are already zero.
   assign cnt_clr = reset || (bus.start && (state_q != RUN));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         case (state_q)
            IDLE, HALT: begin
               if (bus.start) begin
                  state_q <= RUN;
                  pc_q    <= '0;
               end
            end
            RUN: begin
               if (!bus.stall) begin
                  if (is_halt) begin
                     state_q <= HALT;
                  end else if (bus.branch_taken) begin
                     pc_q <= bus.branch_target;
                  end else begin
                     pc_q <= pc_q + PC_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               pc_q    <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk     (clk),
      .clr_i   (cnt_clr),
      .en_i    (state_q == RUN),
      .count_o (bus.cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_inst_cnt (
      .clk     (clk),
      .clr_i   (cnt_clr),
      .en_i    (issue),
      .count_o (bus.inst_count)
   );

   assign bus.pc         = pc_q;
   assign bus.inst_valid = issue;
   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [8:0] rom [256];

   fetch_ctrl_if #(.CNT_W(16)) bus  ();
   fetch_ctrl_if #(.CNT_W(4))  bus4 ();

   fetch_ctrl #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
   fetch_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

   assign bus.inst            = rom[bus.pc];
   assign bus4.inst           = rom[bus4.pc];
   assign bus4.start          = bus.start;
   assign bus4.stall          = bus.stall;
   assign bus4.branch_taken   = bus.branch_taken;
   assign bus4.branch_target  = bus.branch_target;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 0 = idle, 1 = running, 2 = halted; counts are unbounded and clipped on compare.
   int m_st, m_pc, m_cyc, m_ic;

   function automatic int sat(input int n, input int w);
      return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_st = 0; m_pc = 0; m_cyc = 0; m_ic = 0;
      end else if (m_st != 1) begin
         if (bus.start) begin
            m_st = 1; m_pc = 0; m_cyc = 0; m_ic = 0;
         end
      end else begin
         m_cyc++;
         if (!bus.stall) begin
            if (rom[m_pc] == 9'h1FF) m_st = 2;
            else begin
               m_ic++;
               m_pc = bus.branch_taken ? int'(bus.branch_target) : (m_pc + 1) % 256;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_idle_inputs();
      bus.start = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
   endtask

   task automatic test_reset();
      reset = 1; set_idle_inputs();
      tick(); tick();
      reset = 0; #1;
      n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", bus.pc); end
      n_checks++; if ({bus.busy, bus.done, bus.inst_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.inst_valid}); end
      n_checks++; if ({bus.cycle_count, bus.inst_count} !== 32'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.cycle_count, bus.inst_count); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 256; i++) rom[i] = 9'h1FF;
      for (int i = 0; i < 3; i++) rom[i] = 9'h000;
      bus.start = 1; tick(); bus.start = 0; #1;
      n_checks++; if ({bus.busy, bus.pc} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL basic_start got busy=%b pc=%0d exp busy=1 pc=0", bus.busy, bus.pc); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({bus.pc, bus.inst_valid} !== {8'(i), i < 3}) begin
            n_fail++; $display("FAIL basic_seq%0d got pc=%0d v=%b exp pc=%0d v=%b", i, bus.pc, bus.inst_valid, i, i < 3);
         end
         tick();
      end
      n_checks++; if ({bus.done, bus.busy, bus.pc} !== {2'b10, 8'd3}) begin n_fail++; $display("FAIL basic_halt got done=%b busy=%b pc=%0d exp 1 0 3", bus.done, bus.busy, bus.pc); end
      n_checks++; if ({bus.inst_count, bus.cycle_count} !== {16'd3, 16'd4}) begin n_fail++; $display("FAIL basic_counts got inst=%0d cyc=%0d exp 3 4", bus.inst_count, bus.cycle_count); end
   endtask

   task automatic test_restart();
      for (int i = 0; i < 256; i++) rom[i] = 9'(i);
      bus.start = 1; #1;
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done got=%b exp=1", bus.done); end
      tick(); bus.start = 0; #1;
      n_checks++; if ({bus.done, bus.busy, bus.pc} !== {2'b01, 8'd0}) begin n_fail++; $display("FAIL restart_state got done=%b busy=%b pc=%0d exp 0 1 0", bus.done, bus.busy, bus.pc); end
      n_checks++; if ({bus.cycle_count, bus.inst_count} !== 32'd0) begin n_fail++; $display("FAIL restart_counts got %0d/%0d exp 0/0", bus.cycle_count, bus.inst_count); end
   endtask

   task automatic run_to_pc(input logic [7:0] target, input string name);
      int budget = 300;
      while (bus.pc !== target && budget > 0) begin tick(); budget--; end
      n_checks++; if (bus.pc !== target) begin n_fail++; $display("FAIL %s_reach got pc=%0d exp=%0d", name, bus.pc, target); end
   endtask

   task automatic test_branch();
      run_to_pc(8'd5, "branch");
      bus.branch_taken = 1; bus.branch_target = 8'h14; #1;
      n_checks++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL branch_valid got=%b exp=1", bus.inst_valid); end
      tick();
      n_checks++; if (bus.pc !== 8'h14) begin n_fail++; $display("FAIL branch_target got=%0h exp=14", bus.pc); end
      bus.branch_target = 8'd6; tick();
      bus.stall = 1; bus.branch_target = 8'h30; #1;
      n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL branch_stall_valid got=%b exp=0", bus.inst_valid); end
      tick();
      n_checks++; if (bus.pc !== 8'd6) begin n_fail++; $display("FAIL branch_stall_pc got=%0d exp=6", bus.pc); end
      bus.stall = 0; bus.branch_taken = 0; tick();
   endtask

   task automatic test_stall();
      int c0, i0;
      n_checks++; if (bus.pc !== 8'd7) begin n_fail++; $display("FAIL stall_start_pc got=%0d exp=7", bus.pc); end
      c0 = m_cyc; i0 = m_ic;
      bus.stall = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++; if (bus.pc !== 8'd7) begin n_fail++; $display("FAIL stall_hold%0d got=%0d exp=7", k, bus.pc); end
      end
      bus.stall = 0; tick();
      n_checks++; if (bus.pc !== 8'd8) begin n_fail++; $display("FAIL stall_release got=%0d exp=8", bus.pc); end
      n_checks++;
      if ({bus.cycle_count, bus.inst_count} !== {16'(c0 + 3), 16'(i0 + 1)}) begin
         n_fail++; $display("FAIL stall_counts got %0d/%0d exp %0d/%0d", bus.cycle_count, bus.inst_count, c0 + 3, i0 + 1);
      end
      rom[8] = 9'h1FF; bus.stall = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++; if ({bus.busy, bus.done, bus.pc} !== {2'b10, 8'd8}) begin n_fail++; $display("FAIL stall_halt_hold%0d got busy=%b done=%b pc=%0d exp 1 0 8", k, bus.busy, bus.done, bus.pc); end
      end
      bus.stall = 0; #1;
      n_checks++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got=%b exp=0", bus.inst_valid); end
      tick();
      n_checks++; if ({bus.busy, bus.done, bus.pc} !== {2'b01, 8'd8}) begin n_fail++; $display("FAIL stall_halt got busy=%b done=%b pc=%0d exp 0 1 8", bus.busy, bus.done, bus.pc); end
      rom[8] = 9'd8;
   endtask

   task automatic test_wrap();
      bus.branch_taken = 1; bus.branch_target = 8'hFF; tick();
      bus.branch_taken = 0;
      n_checks++; if (bus.pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_setup got=%0d exp=255", bus.pc); end
      tick();
      n_checks++; if ({bus.pc, bus.busy} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL wrap got pc=%0d busy=%b exp 0 1", bus.pc, bus.busy); end
   endtask

   task automatic test_reset_mid();
      bus.branch_taken = 1; bus.branch_target = 8'd40; tick();
      bus.branch_taken = 0;
      n_checks++; if (bus.pc !== 8'd40) begin n_fail++; $display("FAIL rmid_setup got=%0d exp=40", bus.pc); end
      reset = 1; bus.start = 1; tick();
      reset = 0; bus.start = 0; #1;
      n_checks++;
      if ({bus.pc, bus.busy, bus.done, bus.inst_valid, bus.cycle_count, bus.inst_count} !== 43'd0) begin
         n_fail++; $display("FAIL rmid got pc=%0d busy=%b done=%b cyc=%0d inst=%0d exp all 0", bus.pc, bus.busy, bus.done, bus.cycle_count, bus.inst_count);
      end
   endtask

   task automatic test_saturation();
      bus.start = 1; tick(); bus.start = 0; bus.stall = 1;
      repeat (20) tick();
      bus.stall = 0;
      n_checks++; if (bus4.cycle_count !== 4'd15) begin n_fail++; $display("FAIL sat4_cycle got=%0d exp=15", bus4.cycle_count); end
      n_checks++; if (bus.cycle_count !== 16'd20) begin n_fail++; $display("FAIL sat16_cycle got=%0d exp=20", bus.cycle_count); end
      n_checks++; if (bus4.inst_count !== 4'd0) begin n_fail++; $display("FAIL sat4_inst got=%0d exp=0", bus4.inst_count); end
   endtask

   task automatic test_random();
      logic [50:0] got, exp;
      for (int i = 0; i < 256; i++)
         rom[i] = ($urandom_range(0, 19) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
      for (int c = 0; c < 600; c++) begin
         reset              = ($urandom_range(0, 99) < 2);
         bus.start          = ($urandom_range(0, 9) == 0);
         bus.stall          = ($urandom_range(0, 9) < 3);
         bus.branch_taken   = ($urandom_range(0, 3) == 0);
         bus.branch_target  = 8'($urandom_range(0, 255));
         #1;
         got = {bus.pc, bus.busy, bus.done, bus.inst_valid, bus.cycle_count, bus.inst_count,
                bus4.cycle_count, bus4.inst_count};
         exp = {8'(m_pc), m_st == 1, m_st == 2, (m_st == 1) && !bus.stall && (rom[m_pc] != 9'h1FF),
                16'(sat(m_cyc, 16)), 16'(sat(m_ic, 16)), 4'(sat(m_cyc, 4)), 4'(sat(m_ic, 4))};
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random_c%0d got=%h exp=%h", c, got, exp);
         end
         tick();
      end
      reset = 0; set_idle_inputs();
   endtask

   initial begin
      reset = 1; set_idle_inputs();
      for (int i = 0; i < 256; i++) rom[i] = 9'h1FF;
      m_st = 0; m_pc = 0; m_cyc = 0; m_ic = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_restart();
      test_branch();
      test_stall();
      test_restart();
      test_wrap();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
